// File: rtl/question5_pkg.sv
// Shared constants for the question5 serial delay line.
package question5_pkg;

  localparam int unsigned DepthDefault = 3;
  localparam int unsigned WidthDefault = 1;

endpackage

// File: rtl/question5_stage.sv
// One delay-line stage: a Width-bit D flip-flop with a synchronous active-low clear.
module question5_stage #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (!clr_ni) begin
      data_q <= '0;
    end else begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/question5.sv
// Fixed-latency serial delay line: q_o is d_i delayed by exactly Depth rising edges.
module question5
  import question5_pkg::*;
#(
  parameter int unsigned Depth = DepthDefault,
  parameter int unsigned Width = WidthDefault
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  // chain[0] is the input; chain[i+1] is the output of stage i.
  logic [Width-1:0] chain [Depth+1];

  assign chain[0] = d_i;

  for (genvar i = 0; i < Depth; i++) begin : g_stage
    question5_stage #(
      .Width (Width)
    ) u_stage (
      .clk_i  (clk_i),
      .clr_ni (reset_ni),
      .d_i    (chain[i]),
      .q_o    (chain[i+1])
    );
  end

  assign q_o = chain[Depth];

endmodule

// File: tb/tb_question5.sv
// Directed bench for question5 with the default three-stage, 1-bit configuration.
module tb_question5;

  logic       clk;
  logic       reset_n;
  logic [0:0] d;
  logic [0:0] q;

  int checks   = 0;
  int failures = 0;

  question5 u_dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .d_i      (d),
    .q_o      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_q(input logic exp, input string tag);
    checks++;
    assert (q === exp) else begin
      failures++;
      $error("FAIL %s: q=%b expected %b", tag, q, exp);
    end
  endtask

  // Per slot, MSB first: at the falling edge check q, then drive d for the next rising edge.
  task automatic run(input logic [31:0] dv, input logic [31:0] qv, input int n,
                     input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      check_q(qv[i], $sformatf("%s[%0d]", tag, n - 1 - i));
      d = dv[i];
    end
  endtask

  initial begin
    reset_n = 1'b0;
    d       = 1'b1;
    @(posedge clk);

    // Reset edge with d=1 must leave q at 0; then release with d=0.
    @(negedge clk);
    check_q(1'b0, "rst_q");
    reset_n = 1'b1;
    d       = 1'b0;
    run(32'b000, 32'b000, 3, "rel");

    run(32'b1100000, 32'b0001100, 7, "pulse2");
    run(32'b100000, 32'b000100, 6, "pulse1");
    run(32'b0011010000100001, 32'b0000011010000100, 16, "stream");

    // Load 111 while the stream tail drains, then reset mid-stream with d still 1.
    run(32'b111, 32'b001, 3, "load");
    @(negedge clk);
    check_q(1'b1, "pre_rst");
    reset_n = 1'b0;
    d       = 1'b1;
    @(negedge clk);
    check_q(1'b0, "mid_rst");
    reset_n = 1'b1;
    d       = 1'b0;
    run(32'b0000, 32'b0000, 4, "post_rst");

    run(32'b10101010000, 32'b00010101010, 11, "alt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
